// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and helpers for the programmable sequence detector (rev 1.0).
`default_nettype none

package seq_det_pkg;

  typedef enum logic {
    MODE_NONOVL = 1'b0,
    MODE_OVL    = 1'b1
  } mode_e;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Zero or out-of-range lengths select the full pattern width.
  function automatic int clamp_len(input int len, input int max_len);
    return ((len == 0) || (len > max_len)) ? max_len : len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_det_hist.sv
// seq_det_hist: serial history shift register and saturating fill counter (rev 1.0).
`default_nettype none

module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in,
  input  logic                       in_valid,
  input  logic                       load,
  input  logic                       restart,
  output logic [MAX_LEN-1:0]         hist,
  output logic [len_w(MAX_LEN)-1:0]  fill
);

  localparam int LEN_W = len_w(MAX_LEN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist <= '0;
      fill <= '0;
    end else if (load) begin
      hist <= '0;
      fill <= '0;
    end else if (in_valid) begin
      hist <= {hist[MAX_LEN-2:0], in};
      // A non-overlapping match forces a full fresh window before the next hit.
      if (restart)
        fill <= '0;
      else if (fill != LEN_W'(MAX_LEN))
        fill <= fill + LEN_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial pattern detector (rev 1.0).
// Define SEQ_DET_COUNT_EN to build the saturating match counter.
`default_nettype none

module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN = 8,
  parameter logic [MAX_LEN-1:0] RST_PAT = 8'b0000_0101,
  parameter int                 RST_LEN = 3,
  parameter int                 CNT_W   = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in,
  input  logic                      in_valid,
  input  logic                      overlap,
  input  logic                      pat_load,
  input  logic [MAX_LEN-1:0]        pat_in,
  input  logic [len_w(MAX_LEN)-1:0] len_in,
  output logic                      out,
  output logic [CNT_W-1:0]          match_cnt,
  input  logic                      cnt_clr
);

  localparam int             LEN_W = len_w(MAX_LEN);
  localparam logic [LEN_W:0] ONE   = 1;

  logic [MAX_LEN-1:0] pat;
  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   fill;
  logic               match;
  logic               restart;
  logic               hist_msb_unused;
  mode_e              mode;

  seq_det_hist #(
    .MAX_LEN (MAX_LEN)
  ) u_hist (
    .clock    (clock),
    .reset    (reset),
    .in       (in),
    .in_valid (in_valid),
    .load     (pat_load),
    .restart  (restart),
    .hist     (hist),
    .fill     (fill)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pat <= RST_PAT;
      len <= LEN_W'(RST_LEN);
    end else if (pat_load) begin
      pat <= pat_in;
      len <= LEN_W'(clamp_len(int'(len_in), MAX_LEN));
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      mask[i] = (i < int'(len));
  end

  // The incoming bit is part of the compared window so the hit lands on its own edge.
  assign window          = {hist[MAX_LEN-2:0], in};
  assign hist_msb_unused = hist[MAX_LEN-1];
  assign mode            = mode_e'(overlap);
  assign match   = in_valid && !pat_load &&
                   (({1'b0, fill} + ONE) >= {1'b0, len}) &&
                   (((window ^ pat) & mask) == '0);
  assign restart = match && (mode == MODE_NONOVL);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      out <= 1'b0;
    else
      out <= match;
  end

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (cnt_clr)
      cnt <= '0;
    else if (match && (cnt != '1))
      cnt <= cnt + CNT_W'(1);
  end

  assign match_cnt = cnt;
`else
  logic cnt_clr_unused;

  assign cnt_clr_unused = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

`default_nettype wire
